c3lib_scan_seq_ctrl: RTL and testbench
======================================

Name: c3lib_scan_seq_ctrl

Overview:
- Sequencer for a chain of scan-capable reset flops: serially loads a parallel pattern into the chain, runs functional capture cycles, then unloads the chain contents into a parallel response.
- Sits between a test/config agent (valid/ready request and response) and the scan_en/scan_in/scan_out pins of one flop chain.
- Drives one shared scan_en for the whole chain.
- Used for chain integrity checks (loopback) and for single-pattern capture tests.

Parameters:
- CHAIN_LEN, 8: number of flops in the chain. Must be >= 2.
- CAPTURE_CYC, 1: number of functional (scan_en=0) clock cycles in CAPTURE. Must be >= 1.
- CNT_W, $clog2(CHAIN_LEN+CAPTURE_CYC+1): width of the internal cycle counter.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  controller can accept a request
- req_pattern  in  CHAIN_LEN  pattern to load; bit i lands in chain flop i (flop 0 is nearest scan_in)
- req_capture  in  1  1 = run CAPTURE_CYC functional cycles between load and unload; 0 = skip capture (loopback)
- abort  in  1  synchronous abort of an operation in progress
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed
- rsp_data  out  CHAIN_LEN  unloaded chain contents, bit i from flop i
- scan_en  out  1  chain scan enable
- scan_in  out  1  serial data into flop 0
- scan_out  in  1  output of flop CHAIN_LEN-1
- busy  out  1  state != IDLE

Behaviour:
- All outputs registered.
- Reset (async, rst=1) forces state=IDLE, req_ready=1, rsp_valid=0, rsp_data=0, scan_en=0, scan_in=0, busy=0, counter=0.
- States:
  - IDLE: req_ready=1. On req_valid&&req_ready, latch req_pattern and req_capture into shadow registers and go to LOAD.
  - LOAD: CHAIN_LEN cycles with scan_en=1. In load cycle k (k=0..CHAIN_LEN-1), scan_in = pattern[CHAIN_LEN-1-k].
    - Exit to CAPTURE if capture=1, else to UNLOAD.
  - CAPTURE: CAPTURE_CYC cycles with scan_en=0, scan_in=0. Then go to UNLOAD.
  - UNLOAD: CHAIN_LEN cycles with scan_en=1, scan_in=0.
    - In unload cycle k, sample scan_out (before the clock edge that ends the cycle) into rsp_data[CHAIN_LEN-1-k].
    - After the last cycle, go to RESP.
  - RESP: rsp_valid=1, scan_en=0, and rsp_data is held stable. On rsp_ready go to IDLE; rsp_valid drops the following cycle.
- Timing rule: scan_en/scan_in registered values take effect in the cycle after the state transition.
  - The first LOAD cycle starts the cycle after the handshake.
- Latency from handshake to rsp_valid=1:
  - capture=1: 2*CHAIN_LEN+CAPTURE_CYC+1 cycles.
  - capture=0: 2*CHAIN_LEN+1 cycles.
- rsp_data is updated only in UNLOAD. It retains its last value in all other states.
- req_ready=0 in every state other than IDLE. A request held during busy is accepted only after return to IDLE.
- abort=1 in LOAD, CAPTURE or UNLOAD: next cycle state=IDLE, scan_en=0, scan_in=0, counter cleared, no response produced. rsp_data keeps the partial value.
- abort in IDLE or RESP is ignored. In RESP the response must still be handshaken.
- Simultaneous abort and final cycle of UNLOAD: abort wins; no response.
- rsp_ready with rsp_valid=0 is ignored.
- Counter counts 0..len-1 per phase and reloads to 0 at every phase change. It never wraps mid-phase.
- Reset asserted mid-operation returns immediately to the reset values above. The chain contents are undefined afterwards.

Test Plan:
- Loopback, CHAIN_LEN=8, with a behavioral chain built from the team's scan-reset flop model: pattern 8'hA5, capture=0 -> scan_in sequence 1,0,1,0,0,1,0,1; rsp_data=8'hA5; rsp_valid rises 17 cycles after the handshake.
- Capture, CAPTURE_CYC=1, functional data_in of all flops tied to 1: pattern 8'h00, capture=1 -> scan_en low for exactly 1 cycle; rsp_data=8'hFF; latency 18 cycles.
- Backpressure: hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid stays 1, rsp_data stable, req_ready=0. A new req_valid is not accepted until 1 cycle after rsp_ready.
- Abort in LOAD cycle 3 -> next cycle scan_en=0, busy=0, req_ready=1, no rsp_valid pulse. A following request with 8'h3C completes with rsp_data=8'h3C.
- Abort coincident with last UNLOAD cycle -> no response; state IDLE.
- Async reset asserted mid-CAPTURE, between clock edges -> scan_en=0, busy=0, rsp_valid=0 immediately, with no clock edge required.

Source files
------------

// File: rtl/c3lib_scan_seq_ctrl.sv
// Scan chain sequencer: serially loads a pattern, optionally runs functional
// capture cycles, then unloads the chain into a parallel response.
module c3lib_scan_seq_ctrl #(
    parameter int CHAIN_LEN   = 8,
    parameter int CAPTURE_CYC = 1,
    parameter int CNT_W       = $clog2(CHAIN_LEN + CAPTURE_CYC + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [CHAIN_LEN-1:0] req_pattern,
    input  logic                 req_capture,
    input  logic                 abort,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [CHAIN_LEN-1:0] rsp_data,
    output logic                 scan_en,
    output logic                 scan_in,
    input  logic                 scan_out,
    output logic                 busy
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CAPTURE,
        UNLOAD,
        RESP
    } state_t;

    localparam logic [CNT_W-1:0] CHAIN_LAST = CNT_W'(CHAIN_LEN - 1);
    localparam logic [CNT_W-1:0] CAP_LAST   = CNT_W'(CAPTURE_CYC - 1);

    state_t               state;
    logic [CNT_W-1:0]     cnt;
    logic [CHAIN_LEN-1:0] pat_q;
    logic                 cap_q;

    // State and outputs share one edge: the state names the cycle the
    // registered scan_en/scan_in are currently driving.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            pat_q     <= '0;
            cap_q     <= 1'b0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            scan_en   <= 1'b0;
            scan_in   <= 1'b0;
            busy      <= 1'b0;
        end else if (abort && (state == LOAD || state == CAPTURE || state == UNLOAD)) begin
            state     <= IDLE;
            cnt       <= '0;
            scan_en   <= 1'b0;
            scan_in   <= 1'b0;
            req_ready <= 1'b1;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        state     <= LOAD;
                        cnt       <= '0;
                        pat_q     <= req_pattern << 1;
                        cap_q     <= req_capture;
                        scan_en   <= 1'b1;
                        scan_in   <= req_pattern[CHAIN_LEN-1];
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                    end
                end
                LOAD: begin
                    if (cnt == CHAIN_LAST) begin
                        cnt     <= '0;
                        scan_in <= 1'b0;
                        if (cap_q) begin
                            state   <= CAPTURE;
                            scan_en <= 1'b0;
                        end else begin
                            state   <= UNLOAD;
                            scan_en <= 1'b1;
                        end
                    end else begin
                        cnt     <= cnt + CNT_W'(1);
                        scan_in <= pat_q[CHAIN_LEN-1];
                        pat_q   <= pat_q << 1;
                    end
                end
                CAPTURE: begin
                    if (cnt == CAP_LAST) begin
                        state   <= UNLOAD;
                        cnt     <= '0;
                        scan_en <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                UNLOAD: begin
                    for (int unsigned i = 0; i < CHAIN_LEN; i++) begin
                        if (cnt == CNT_W'(CHAIN_LEN - 1 - i))
                            rsp_data[i] <= scan_out;
                    end
                    if (cnt == CHAIN_LAST) begin
                        state     <= RESP;
                        cnt       <= '0;
                        scan_en   <= 1'b0;
                        rsp_valid <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    cnt       <= '0;
                    scan_en   <= 1'b0;
                    scan_in   <= 1'b0;
                    rsp_valid <= 1'b0;
                    req_ready <= 1'b1;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_c3lib_scan_seq_ctrl.sv
// Bench for c3lib_scan_seq_ctrl driving a behavioral scan-reset flop chain.
module tb_c3lib_scan_seq_ctrl;

    localparam int N = 8;
    localparam int C = 1;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic [N-1:0] req_pattern = '0;
    logic         req_capture = 1'b0;
    logic         abort = 1'b0;
    logic         rsp_valid;
    logic         rsp_ready = 1'b0;
    logic [N-1:0] rsp_data;
    logic         scan_en;
    logic         scan_in;
    logic         scan_out;
    logic         busy;

    logic [N-1:0] chain;
    logic [N-1:0] func_d = '0;
    logic [N-1:0] exp_q[$];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Scan-reset flops: flop 0 nearest scan_in, functional data when scan_en=0.
    always_ff @(posedge clk) begin
        if (scan_en) chain <= {chain[N-2:0], scan_in};
        else         chain <= func_d;
    end
    assign scan_out = chain[N-1];

    c3lib_scan_seq_ctrl #(.CHAIN_LEN(N), .CAPTURE_CYC(C)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_pattern (req_pattern),
        .req_capture (req_capture),
        .abort       (abort),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_data    (rsp_data),
        .scan_en     (scan_en),
        .scan_in     (scan_in),
        .scan_out    (scan_out),
        .busy        (busy)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [N-1:0] pat, input logic cap);
        int w = 0;
        while (!req_ready && w < 50) begin
            tick();
            w++;
        end
        check_val("req_ready_wait", req_ready, 1);
        req_valid   = 1'b1;
        req_pattern = pat;
        req_capture = cap;
        tick();
        req_valid = 1'b0;
        exp_q.push_back(cap ? func_d : pat);
        check_val("accept_busy", busy, 1);
        check_val("accept_req_ready", req_ready, 0);
    endtask

    task automatic finish(input logic [N-1:0] pat, input logic cap, input int hold,
                          input logic queue_next, input logic [N-1:0] next_pat);
        int           lat = 1;
        int           en_cnt = 0;
        int           low_cnt = 0;
        logic [N-1:0] seq = '0;
        logic [N-1:0] exp = '0;
        while (!rsp_valid && lat < 200) begin
            if (lat <= N) seq[N-lat] = scan_in;
            if (scan_en) en_cnt++;
            else         low_cnt++;
            tick();
            lat++;
        end
        check_val("latency", lat, cap ? 2*N + C + 1 : 2*N + 1);
        check_val("load_seq", seq, pat);
        check_val("scan_en_cycles", en_cnt, 2*N);
        check_val("capture_cycles", low_cnt, cap ? C : 0);
        if (exp_q.size() > 0) exp = exp_q.pop_front();
        if (queue_next) begin
            req_valid   = 1'b1;
            req_pattern = next_pat;
            req_capture = 1'b0;
        end
        for (int h = 0; h < hold; h++) begin
            check_val("hold_rsp_valid", rsp_valid, 1);
            check_val("hold_rsp_data", rsp_data, exp);
            check_val("hold_req_ready", req_ready, 0);
            tick();
        end
        rsp_ready = 1'b1;
        check_val("rsp_valid", rsp_valid, 1);
        check_val("rsp_data", rsp_data, exp);
        check_val("resp_scan_en", scan_en, 0);
        tick();
        rsp_ready = 1'b0;
        check_val("rsp_valid_drop", rsp_valid, 0);
        check_val("idle_req_ready", req_ready, 1);
        check_val("idle_busy", busy, 0);
    endtask

    task automatic watch_no_rsp(input string tag);
        int seen = 0;
        repeat (25) begin
            if (rsp_valid) seen++;
            tick();
        end
        check_val(tag, seen, 0);
    endtask

    initial begin
        #12;
        check_val("rst_req_ready", req_ready, 1);
        check_val("rst_rsp_valid", rsp_valid, 0);
        check_val("rst_rsp_data", rsp_data, 0);
        check_val("rst_scan_en", scan_en, 0);
        check_val("rst_scan_in", scan_in, 0);
        check_val("rst_busy", busy, 0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // loopback
        func_d = 8'h00;
        issue(8'hA5, 1'b0);
        finish(8'hA5, 1'b0, 0, 1'b0, '0);

        // capture with functional inputs tied high
        func_d = 8'hFF;
        issue(8'h00, 1'b1);
        finish(8'h00, 1'b1, 0, 1'b0, '0);

        // backpressure with a new request waiting
        func_d = 8'h00;
        issue(8'h96, 1'b0);
        finish(8'h96, 1'b0, 5, 1'b1, 8'h5A);
        issue(8'h5A, 1'b0);
        finish(8'h5A, 1'b0, 0, 1'b0, '0);

        // abort in load cycle 3
        issue(8'hFF, 1'b0);
        repeat (3) tick();
        check_val("pre_abort_scan_en", scan_en, 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_val("abort_load_scan_en", scan_en, 0);
        check_val("abort_load_busy", busy, 0);
        check_val("abort_load_req_ready", req_ready, 1);
        watch_no_rsp("abort_load_no_rsp");
        if (exp_q.size() > 0) void'(exp_q.pop_back());
        issue(8'h3C, 1'b0);
        finish(8'h3C, 1'b0, 0, 1'b0, '0);

        // abort coincident with last unload cycle
        func_d = 8'h5A;
        issue(8'h81, 1'b1);
        repeat (16) tick();
        check_val("last_unload_scan_en", scan_en, 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_val("abort_unload_busy", busy, 0);
        check_val("abort_unload_rsp_valid", rsp_valid, 0);
        check_val("abort_unload_req_ready", req_ready, 1);
        check_val("abort_unload_scan_en", scan_en, 0);
        watch_no_rsp("abort_unload_no_rsp");
        if (exp_q.size() > 0) void'(exp_q.pop_back());

        // random loopback and capture
        begin
            logic [N-1:0] rp;
            rp = N'($urandom);
            issue(rp, 1'b0);
            finish(rp, 1'b0, 2, 1'b0, '0);
            func_d = N'($urandom);
            rp = N'($urandom);
            issue(rp, 1'b1);
            finish(rp, 1'b1, 1, 1'b0, '0);
        end

        // async reset mid-capture, between clock edges
        issue(8'h00, 1'b1);
        repeat (8) tick();
        check_val("capture_busy", busy, 1);
        check_val("capture_req_ready", req_ready, 0);
        #2;
        rst = 1'b1;
        #1;
        check_val("async_rst_scan_en", scan_en, 0);
        check_val("async_rst_busy", busy, 0);
        check_val("async_rst_rsp_valid", rsp_valid, 0);
        check_val("async_rst_req_ready", req_ready, 1);
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        tick();

        func_d = 8'h00;
        issue(8'hC3, 1'b0);
        finish(8'hC3, 1'b0, 0, 1'b0, '0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
